// File: rtl/usb_eps_arb.sv
// Endpoint-status RAM arbiter: transaction engine > init sweep > bus, 3-stage pipe.
// Define USB_EPS_INIT_CLEAR_EN to compile in the post-reset clear sweep.
module usb_eps_arb #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tr_read_0,
   input  logic              tr_write_0,
   input  logic              tr_zero_0,
   input  logic [ADDR_W-1:0] tr_addr_0,
   input  logic [DATA_W-1:0] tr_wrdata_0,
   output logic [DATA_W-1:0] tr_rddata_3,
   input  logic              bus_req,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic              bus_ack,
   output logic [DATA_W-1:0] bus_rdata,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic              ram_re,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              init_busy
);

   typedef enum logic [1:0] {OWN_TR, OWN_INIT, OWN_BUS} own_t;

   typedef struct packed {
      logic              v;
      own_t              own;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} bus_st_t;

   cmd_t              nxt, s1, s2;
   logic              s3_v, s3_we;
   own_t              s3_own;
   logic [DATA_W-1:0] tr_hold;
   logic              tr_cmd, sweep_go, bus_go, tr_rd;
   logic [ADDR_W-1:0] sweep_addr;
   bus_st_t           bus_st, bus_nxt;

   assign tr_cmd   = tr_read_0 | tr_write_0;
   assign sweep_go = init_busy & ~tr_cmd;

`ifdef USB_EPS_INIT_CLEAR_EN
   // MSB of the counter flags sweep completion; it never wraps.
   logic [ADDR_W:0] sweep_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sweep_cnt <= '0;
      else if (sweep_go)
         sweep_cnt <= sweep_cnt + (ADDR_W+1)'(1);
   end

   assign init_busy  = ~sweep_cnt[ADDR_W];
   assign sweep_addr = sweep_cnt[ADDR_W-1:0];
`else
   assign init_busy  = 1'b0;
   assign sweep_addr = '0;
`endif

   always_comb begin
      bus_nxt = bus_st;
      bus_go  = 1'b0;
      case (bus_st)
         IDLE: if (bus_req && !tr_cmd && !init_busy) begin
            bus_go  = 1'b1;
            bus_nxt = WAIT;
         end
         WAIT: if (bus_ack) bus_nxt = HOLD;
         HOLD: bus_nxt = IDLE;
         default: bus_nxt = IDLE;
      endcase
   end

   always_comb begin
      nxt = '0;
      unique case (1'b1)
         tr_cmd: begin
            nxt.v    = 1'b1;
            nxt.own  = OWN_TR;
            nxt.we   = tr_write_0;
            nxt.addr = tr_addr_0;
            nxt.data = tr_zero_0 ? '0 : tr_wrdata_0;
         end
         sweep_go: begin
            nxt.v    = 1'b1;
            nxt.own  = OWN_INIT;
            nxt.we   = 1'b1;
            nxt.addr = sweep_addr;
         end
         bus_go: begin
            nxt.v    = 1'b1;
            nxt.own  = OWN_BUS;
            nxt.we   = bus_we;
            nxt.addr = bus_addr;
            nxt.data = bus_wdata;
         end
         default: ;
      endcase
   end

   assign tr_rd = s3_v & (s3_own == OWN_TR) & ~s3_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         s3_v    <= 1'b0;
         s3_we   <= 1'b0;
         s3_own  <= OWN_TR;
         tr_hold <= '0;
         bus_st  <= IDLE;
      end else begin
         s1      <= nxt;
         s2      <= s1;
         s3_v    <= s2.v;
         s3_we   <= s2.we;
         s3_own  <= s2.own;
         bus_st  <= bus_nxt;
         if (tr_rd)
            tr_hold <= ram_rdata;
      end
   end

   // S2 drives the RAM; the RAM output register acts as the S3 data stage.
   assign ram_re    = s2.v & ~s2.we;
   assign ram_we    = s2.v & s2.we;
   assign ram_raddr = s2.addr;
   assign ram_waddr = s2.addr;
   assign ram_wdata = s2.data;

   assign bus_ack     = s3_v & (s3_own == OWN_BUS);
   assign bus_rdata   = (bus_ack && !s3_we) ? ram_rdata : '0;
   assign tr_rddata_3 = tr_rd ? ram_rdata : tr_hold;

endmodule

// File: tb/tb_usb_eps_arb.sv
// Randomized scoreboard bench for usb_eps_arb with a behavioural RAM model.
// Honours USB_EPS_INIT_CLEAR_EN the same way as the design.
module tb_usb_eps_arb;

`ifdef USB_EPS_INIT_CLEAR_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tr_read_0 = 0, tr_write_0 = 0, tr_zero_0 = 0;
   logic [7:0]  tr_addr_0 = 0;
   logic [15:0] tr_wrdata_0 = 0;
   logic [15:0] tr_rddata_3;
   logic        bus_req = 0, bus_we = 0;
   logic [7:0]  bus_addr = 0;
   logic [15:0] bus_wdata = 0;
   logic        bus_ack;
   logic [15:0] bus_rdata;
   logic [7:0]  ram_raddr, ram_waddr;
   logic        ram_re, ram_we;
   logic [15:0] ram_wdata, ram_rdata;
   logic        init_busy;

   usb_eps_arb dut (
      .clk(clk), .rst(rst),
      .tr_read_0(tr_read_0), .tr_write_0(tr_write_0),
      .tr_zero_0(tr_zero_0), .tr_addr_0(tr_addr_0),
      .tr_wrdata_0(tr_wrdata_0), .tr_rddata_3(tr_rddata_3),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
      .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // Status RAM: 1-cycle synchronous read, preload port used under reset.
   logic [15:0] mem [256];
   logic [15:0] rd;
   logic        pre_en = 0;
   logic [7:0]  pre_addr = 0;
   logic [15:0] pre_data = 0;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) rd <= mem[ram_raddr];
   end
   assign ram_rdata = rd;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   exp_t        trq[$];
   exp_t        bq[$];
   logic [15:0] gold [256];
   int          now = 0;
   int          vectors = 0;
   int          errs = 0;
   bit          pend = 0, inflight = 0;
   int          ack_cyc = 0, next_ok = 0, streak = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h",
                  nm, now, act, exp);
      end
   endtask

   // Model: one command slot per cycle, issue order defines memory order.
   task automatic step(input bit t_rd, input bit t_wr, input bit t_zero,
                       input logic [7:0] t_a, input logic [15:0] t_d,
                       input bit b_new, input bit b_we,
                       input logic [7:0] b_a, input logic [15:0] b_d);
      @(posedge clk); #1;
      now++;
      if (inflight && now > ack_cyc) begin
         inflight = 0;
         bus_req  = 0;
      end
      if (b_new && !pend && !inflight) begin
         pend      = 1;
         bus_req   = 1;
         bus_we    = b_we;
         bus_addr  = b_a;
         bus_wdata = b_d;
      end
      tr_read_0   = t_rd;
      tr_write_0  = t_wr & !t_rd;
      tr_zero_0   = t_zero;
      tr_addr_0   = t_a;
      tr_wrdata_0 = t_d;
      if (tr_read_0) begin
         trq.push_back('{now + 3, gold[t_a]});
      end else if (tr_write_0) begin
         gold[t_a] = t_zero ? 16'h0 : t_d;
      end else if (pend && now >= next_ok) begin
         bq.push_back('{now + 3, bus_we ? 16'h0 : gold[bus_addr]});
         if (bus_we) gold[bus_addr] = bus_wdata;
         pend     = 0;
         inflight = 1;
         ack_cyc  = now + 3;
         next_ok  = now + 5;
      end
      streak = (tr_read_0 || tr_write_0) ? streak + 1 : 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
   endtask

   task automatic bus_xfer(input bit we, input logic [7:0] a,
                           input logic [15:0] d);
      step(0, 0, 0, 8'h0, 16'h0, 1, we, a, d);
      for (int k = 0; k < 20 && (pend || inflight); k++) idle();
      chk("bus_xfer_timeout", {31'b0, pend | inflight}, 0);
   endtask

   task automatic after_reset();
`ifdef USB_EPS_INIT_CLEAR_EN
      int n = 0;
      for (int k = 0; k < 400; k++) begin
         if (!init_busy) break;
         n++;
         idle();
      end
      chk("init_busy_cycles", n, 256);
      for (int a = 0; a < 256; a++) gold[a] = 16'h0;
`else
      chk("init_busy_off", {31'b0, init_busy}, 0);
`endif
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         now++;
         rst = 1;
         tr_read_0 = 0; tr_write_0 = 0; tr_zero_0 = 0;
         bus_req = 0;
         pend = 0; inflight = 0; next_ok = 0; streak = 0;
         trq.delete();
         bq.delete();
      end
      @(posedge clk); #1;
      now++;
      rst = 0;
   endtask

   task automatic rand_step();
      bit t, r;
      t = (streak < 3) && ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 1) == 1;
      step(t & r, t & !r, $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 15)), 16'($urandom));
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         chk("rst_bus_ack", {31'b0, bus_ack}, 0);
         chk("rst_bus_rdata", {16'b0, bus_rdata}, 0);
         chk("rst_tr_rddata", {16'b0, tr_rddata_3}, 0);
         chk("rst_ram_en", {30'b0, ram_we, ram_re}, 0);
         chk("rst_init_busy", {31'b0, init_busy}, {31'b0, INIT_EN});
      end else begin
         if (trq.size() != 0 && trq[0].cyc == now) begin
            e = trq.pop_front();
            chk("tr_rddata_3", {16'b0, tr_rddata_3}, {16'b0, e.data});
         end
         if (bus_ack) begin
            if (bq.size() == 0) begin
               chk("unexpected_bus_ack", 1, 0);
            end else begin
               e = bq.pop_front();
               chk("bus_ack_cycle", now, e.cyc);
               chk("bus_rdata", {16'b0, bus_rdata}, {16'b0, e.data});
            end
         end else begin
            chk("bus_rdata_idle", {16'b0, bus_rdata}, 0);
            if (bq.size() != 0 && bq[0].cyc < now) begin
               e = bq.pop_front();
               chk("missing_bus_ack", now, e.cyc);
            end
         end
      end
   end

   initial begin
      pre_en = 1;
      for (int a = 0; a < 256; a++) begin
         @(posedge clk); #1;
         pre_addr = 8'(a);
         pre_data = INIT_EN ? 16'hFFFF : 16'($urandom);
         gold[a]  = pre_data;
      end
      @(posedge clk); #1;
      pre_en = 0;
      now++;
      rst = 0;
      after_reset();

      step(0, 1, 0, 8'h12, 16'hA5C3, 0, 0, 8'h0, 16'h0);
      step(1, 0, 0, 8'h12, 16'h0, 0, 0, 8'h0, 16'h0);
      repeat (4) idle();
      step(0, 1, 1, 8'h07, 16'hFFFF, 0, 0, 8'h0, 16'h0);
      bus_xfer(0, 8'h07, 16'h0);
      bus_xfer(0, 8'h40, 16'h0);
      for (int k = 0; k < 3; k++)
         step(1, 0, 0, 8'h12, 16'h0, 1, 0, 8'h40, 16'h0);
      for (int k = 0; k < 12; k++) idle();

      for (int k = 0; k < 3000; k++) rand_step();
      for (int k = 0; k < 12; k++) idle();

      for (int a = 0; a < 256; a++) bus_xfer(0, 8'(a), 16'h0);

      bus_xfer(1, 8'h40, 16'h1234);
      repeat (3) idle();
      step(0, 0, 0, 8'h0, 16'h0, 1, 0, 8'h40, 16'h0);
      do_reset(3);
      after_reset();
      bus_xfer(0, 8'h40, 16'h0);

      for (int k = 0; k < 1000; k++) rand_step();
      for (int k = 0; k < 12; k++) idle();
      chk("queues_drained", trq.size() + bq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
